mod_n_seq_checker: RTL and testbench

//  Receive-side monitor for a mod-N counter output stream. Samples the count each enabled cycle,

---
 rtl/mod_n_seq_checker.sv | 199 +++++++++++++++++++
 tb/tb_mod_n_seq_checker.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mod_n_seq_checker.sv
// rtl/mod_n_seq_checker.sv - receive-side monitor for a mod-N counter output stream
//
// Purpose:
//   Samples an observed mod-N count on every enabled cycle, predicts the next
//   value and flags any departure from 0,1,...,N-1,0,... once the stream has
//   been tracked long enough to be trusted. Errors and correct wrap-arounds
//   are counted.
//
// Configuration macro:
//   MODN_CHK_RESYNC_EN  defined   -> FAULT re-acquires on the next enabled sample
//                       undefined -> FAULT is left only by reset or seq_restart_i
//
// Ports:
//   clk_i          rising-edge clock
//   reset_i        synchronous active-high reset, overrides every other input
//   sample_en_i    1 = q_in_i is sampled this cycle, 0 = hold everything
//   seq_restart_i  source restarted legitimately; re-acquire from q_in_i
//   q_in_i         observed counter value
//   locked_o       stream matched for at least LOCK_CNT transitions
//   fault_o        checker sits in FAULT
//   err_pulse_o    one-cycle pulse per detected sequence error
//   expected_o     predicted next value
//   err_count_o    saturating error count
//   wrap_count_o   free-running count of correct N-1 -> 0 steps while locked

module mod_n_seq_checker #(
    parameter int N        = 10,
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             sample_en_i,
    input  logic             seq_restart_i,
    input  logic [WIDTH-1:0] q_in_i,
    output logic             locked_o,
    output logic             fault_o,
    output logic             err_pulse_o,
    output logic [WIDTH-1:0] expected_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [CNT_W-1:0] wrap_count_o
);

    localparam int               GW   = $clog2(LOCK_CNT + 1);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);
    localparam logic [GW-1:0]    GOOD_LOCK = GW'(LOCK_CNT);

    typedef enum logic [1:0] {
        ST_ACQ    = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [GW-1:0]    good_q, good_d;
    logic             locked_q, locked_d;
    logic             fault_q, fault_d;
    logic             err_pulse_q, err_pulse_d;
    logic [WIDTH-1:0] expected_q, expected_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] wrap_count_q, wrap_count_d;

    logic             in_range;
    logic             match;
    logic [GW-1:0]    good_inc;

    function automatic logic [WIDTH-1:0] succ(input logic [WIDTH-1:0] v);
        return (v == LAST) ? '0 : v + WIDTH'(1);
    endfunction

    assign in_range = (q_in_i <= LAST);
    // Compare against the successor of prev directly so the prediction does
    // not depend on when expected_q was last refreshed.
    assign match    = in_range && (q_in_i == succ(prev_q));
    assign good_inc = good_q + GW'(1);

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        good_d       = good_q;
        locked_d     = locked_q;
        fault_d      = fault_q;
        err_pulse_d  = 1'b0;
        expected_d   = expected_q;
        err_count_d  = err_count_q;
        wrap_count_d = wrap_count_q;

        if (sample_en_i) begin
            if (seq_restart_i) begin
                locked_d = 1'b0;
                fault_d  = 1'b0;
                good_d   = '0;
                if (in_range) begin
                    prev_d  = q_in_i;
                    state_d = ST_TRACK;
                end else begin
                    prev_d  = '0;
                    state_d = ST_ACQ;
                end
            end else begin
                case (state_q)
                    ST_ACQ: begin
                        if (in_range) begin
                            prev_d  = q_in_i;
                            good_d  = '0;
                            state_d = ST_TRACK;
                        end
                    end
                    ST_TRACK: begin
                        if (match) begin
                            prev_d = q_in_i;
                            good_d = good_inc;
                            if (good_inc == GOOD_LOCK) begin
                                locked_d = 1'b1;
                                state_d  = ST_LOCKED;
                            end
                        end else if (in_range) begin
                            prev_d = q_in_i;
                            good_d = '0;
                        end else begin
                            prev_d  = '0;
                            good_d  = '0;
                            state_d = ST_ACQ;
                        end
                    end
                    ST_LOCKED: begin
                        if (match) begin
                            prev_d = q_in_i;
                            if (prev_q == LAST) begin
                                wrap_count_d = wrap_count_q + CNT_W'(1);
                            end
                        end else begin
                            err_pulse_d = 1'b1;
                            if (~&err_count_q) begin
                                err_count_d = err_count_q + CNT_W'(1);
                            end
                            locked_d = 1'b0;
                            fault_d  = 1'b1;
                            state_d  = ST_FAULT;
                        end
                    end
                    ST_FAULT: begin
`ifdef MODN_CHK_RESYNC_EN
                        fault_d = 1'b0;
                        good_d  = '0;
                        if (in_range) begin
                            prev_d  = q_in_i;
                            state_d = ST_TRACK;
                        end else begin
                            prev_d  = '0;
                            state_d = ST_ACQ;
                        end
`else
                        // Terminal: only reset or seq_restart_i leave FAULT.
                        state_d = ST_FAULT;
`endif
                    end
                    default: state_d = ST_ACQ;
                endcase
            end
            expected_d = succ(prev_d);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_ACQ;
            prev_q       <= '0;
            good_q       <= '0;
            locked_q     <= 1'b0;
            fault_q      <= 1'b0;
            err_pulse_q  <= 1'b0;
            expected_q   <= '0;
            err_count_q  <= '0;
            wrap_count_q <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            good_q       <= good_d;
            locked_q     <= locked_d;
            fault_q      <= fault_d;
            err_pulse_q  <= err_pulse_d;
            expected_q   <= expected_d;
            err_count_q  <= err_count_d;
            wrap_count_q <= wrap_count_d;
        end
    end

    assign locked_o     = locked_q;
    assign fault_o      = fault_q;
    assign err_pulse_o  = err_pulse_q;
    assign expected_o   = expected_q;
    assign err_count_o  = err_count_q;
    assign wrap_count_o = wrap_count_q;

endmodule

// File: tb/tb_mod_n_seq_checker.sv
// tb/tb_mod_n_seq_checker.sv - directed table-driven bench for mod_n_seq_checker

module tb_mod_n_seq_checker;

    logic       clk;
    logic       reset;
    logic       sample_en;
    logic       seq_restart;
    logic [3:0] q_in;
    logic       locked;
    logic       fault;
    logic       err_pulse;
    logic [3:0] expected;
    logic [7:0] err_count;
    logic [7:0] wrap_count;

    int total;
    int bad;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic       rs;
        logic [3:0] q;
        logic       l;
        logic       f;
        logic       e;
        logic [3:0] x;
        logic [7:0] ec;
        logic [7:0] wc;
    } vec_t;

    vec_t tbl[$];

    mod_n_seq_checker #(
        .N(10), .WIDTH(4), .LOCK_CNT(2), .CNT_W(8)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .sample_en_i   (sample_en),
        .seq_restart_i (seq_restart),
        .q_in_i        (q_in),
        .locked_o      (locked),
        .fault_o       (fault),
        .err_pulse_o   (err_pulse),
        .expected_o    (expected),
        .err_count_o   (err_count),
        .wrap_count_o  (wrap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic rst, input logic en, input logic rs, input logic [3:0] q,
                       input logic l, input logic f, input logic e, input logic [3:0] x,
                       input logic [7:0] ec, input logic [7:0] wc);
        vec_t v;
        v = '{rst: rst, en: en, rs: rs, q: q, l: l, f: f, e: e, x: x, ec: ec, wc: wc};
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s idx=%0d got=%0d want=%0d", name, idx, got, want);
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic rs, input logic [3:0] q);
        reset       = rst;
        sample_en   = en;
        seq_restart = rs;
        q_in        = q;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int idx, input vec_t v);
        chk({tag, ".locked"},     idx, 32'(locked),     32'(v.l));
        chk({tag, ".fault"},      idx, 32'(fault),      32'(v.f));
        chk({tag, ".err_pulse"},  idx, 32'(err_pulse),  32'(v.e));
        chk({tag, ".expected"},   idx, 32'(expected),   32'(v.x));
        chk({tag, ".err_count"},  idx, 32'(err_count),  32'(v.ec));
        chk({tag, ".wrap_count"}, idx, 32'(wrap_count), 32'(v.wc));
    endtask

    initial begin
        logic [3:0] wseq [10];
        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        sample_en   = 1'b0;
        seq_restart = 1'b0;
        q_in        = 4'd0;

        //  rst en rs q      l  f  e  x     ec    wc
        // reset while sampling a value: everything clears
        add(1, 1, 0, 4'd7,  0, 0, 0, 4'd0, 8'd0, 8'd0);
        // acquire 0, track 1, lock on 2, run through a wrap
        add(0, 1, 0, 4'd0,  0, 0, 0, 4'd1, 8'd0, 8'd0);
        add(0, 1, 0, 4'd1,  0, 0, 0, 4'd2, 8'd0, 8'd0);
        add(0, 1, 0, 4'd2,  1, 0, 0, 4'd3, 8'd0, 8'd0);
        add(0, 1, 0, 4'd3,  1, 0, 0, 4'd4, 8'd0, 8'd0);
        add(0, 1, 0, 4'd4,  1, 0, 0, 4'd5, 8'd0, 8'd0);
        add(0, 1, 0, 4'd5,  1, 0, 0, 4'd6, 8'd0, 8'd0);
        add(0, 1, 0, 4'd6,  1, 0, 0, 4'd7, 8'd0, 8'd0);
        add(0, 1, 0, 4'd7,  1, 0, 0, 4'd8, 8'd0, 8'd0);
        add(0, 1, 0, 4'd8,  1, 0, 0, 4'd9, 8'd0, 8'd0);
        add(0, 1, 0, 4'd9,  1, 0, 0, 4'd0, 8'd0, 8'd0);
        add(0, 1, 0, 4'd0,  1, 0, 0, 4'd1, 8'd0, 8'd1);
        add(0, 1, 0, 4'd1,  1, 0, 0, 4'd2, 8'd0, 8'd1);
        // 2,3,4 then skip to 6: one error pulse
        add(0, 1, 0, 4'd2,  1, 0, 0, 4'd3, 8'd0, 8'd1);
        add(0, 1, 0, 4'd3,  1, 0, 0, 4'd4, 8'd0, 8'd1);
        add(0, 1, 0, 4'd4,  1, 0, 0, 4'd5, 8'd0, 8'd1);
        add(0, 1, 0, 4'd6,  0, 1, 1, 4'd5, 8'd1, 8'd1);
`ifdef MODN_CHK_RESYNC_EN
        add(0, 1, 0, 4'd7,  0, 0, 0, 4'd8, 8'd1, 8'd1);
        add(0, 1, 0, 4'd8,  0, 0, 0, 4'd9, 8'd1, 8'd1);
        add(0, 1, 0, 4'd9,  1, 0, 0, 4'd0, 8'd1, 8'd1);
`else
        add(0, 1, 0, 4'd7,  0, 1, 0, 4'd5, 8'd1, 8'd1);
        add(0, 1, 0, 4'd8,  0, 1, 0, 4'd5, 8'd1, 8'd1);
        add(0, 1, 0, 4'd9,  0, 1, 0, 4'd5, 8'd1, 8'd1);
`endif
        // restart at 0, relock at 2, run to 4, then out-of-range 12 is an error
        add(0, 1, 1, 4'd0,  0, 0, 0, 4'd1, 8'd1, 8'd1);
        add(0, 1, 0, 4'd1,  0, 0, 0, 4'd2, 8'd1, 8'd1);
        add(0, 1, 0, 4'd2,  1, 0, 0, 4'd3, 8'd1, 8'd1);
        add(0, 1, 0, 4'd3,  1, 0, 0, 4'd4, 8'd1, 8'd1);
        add(0, 1, 0, 4'd4,  1, 0, 0, 4'd5, 8'd1, 8'd1);
        add(0, 1, 0, 4'd12, 0, 1, 1, 4'd5, 8'd2, 8'd1);
        // restart with out-of-range value lands in ACQ; 12,15 ignored there
        add(0, 1, 1, 4'd12, 0, 0, 0, 4'd1, 8'd2, 8'd1);
        add(0, 1, 0, 4'd12, 0, 0, 0, 4'd1, 8'd2, 8'd1);
        add(0, 1, 0, 4'd15, 0, 0, 0, 4'd1, 8'd2, 8'd1);
        // acquire 3, lock at 5, stall five cycles, resume with 6
        add(0, 1, 0, 4'd3,  0, 0, 0, 4'd4, 8'd2, 8'd1);
        add(0, 1, 0, 4'd4,  0, 0, 0, 4'd5, 8'd2, 8'd1);
        add(0, 1, 0, 4'd5,  1, 0, 0, 4'd6, 8'd2, 8'd1);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 4'd3, 1, 0, 0, 4'd6, 8'd2, 8'd1);
        add(0, 1, 0, 4'd6,  1, 0, 0, 4'd7, 8'd2, 8'd1);
        // legitimate restart at 0 while locked, relock on 2
        add(0, 1, 1, 4'd0,  0, 0, 0, 4'd1, 8'd2, 8'd1);
        add(0, 1, 0, 4'd1,  0, 0, 0, 4'd2, 8'd2, 8'd1);
        add(0, 1, 0, 4'd2,  1, 0, 0, 4'd3, 8'd2, 8'd1);
        // third error, then reset mid-operation with sampling active
        add(0, 1, 0, 4'd5,  0, 1, 1, 4'd3, 8'd3, 8'd1);
        add(1, 1, 0, 4'd7,  0, 0, 0, 4'd0, 8'd0, 8'd0);
        // after reset: ACQ ignores 12, acquires 9; restart without enable is ignored
        add(0, 1, 0, 4'd12, 0, 0, 0, 4'd1, 8'd0, 8'd0);
        add(0, 1, 0, 4'd9,  0, 0, 0, 4'd0, 8'd0, 8'd0);
        add(0, 0, 1, 4'd3,  0, 0, 0, 4'd0, 8'd0, 8'd0);
        // 9->0 while only tracking does not count as a wrap
        add(0, 1, 0, 4'd0,  0, 0, 0, 4'd1, 8'd0, 8'd0);
        add(0, 1, 0, 4'd1,  1, 0, 0, 4'd2, 8'd0, 8'd0);

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].rs, tbl[i].q);
            chk_all("vec", i, tbl[i]);
        end

        // error counter saturation: lock then mismatch, 300 times
        for (int i = 0; i < 300; i++) begin
            step(0, 1, 1, 4'd0);
            step(0, 1, 0, 4'd1);
            step(0, 1, 0, 4'd2);
            step(0, 1, 0, 4'd5);
            if (i == 253) chk("sat.err_count_254", i, 32'(err_count), 32'd254);
            if (i == 254) chk("sat.err_count_255", i, 32'(err_count), 32'd255);
        end
        chk("sat.err_count", 300, 32'(err_count), 32'd255);
        chk("sat.err_pulse", 300, 32'(err_pulse), 32'd1);
        chk("sat.fault",     300, 32'(fault),     32'd1);

        // wrap counter rolls over modulo 256
        step(0, 1, 1, 4'd0);
        step(0, 1, 0, 4'd1);
        step(0, 1, 0, 4'd2);
        chk("wrap.locked", 0, 32'(locked), 32'd1);
        wseq = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
        for (int i = 0; i < 257; i++) begin
            for (int j = 0; j < 10; j++) step(0, 1, 0, wseq[j]);
            if (i == 0)   chk("wrap.count_1",   i, 32'(wrap_count), 32'd1);
            if (i == 255) chk("wrap.count_256", i, 32'(wrap_count), 32'd0);
        end
        chk("wrap.count_257", 257, 32'(wrap_count), 32'd1);
        chk("wrap.locked_end", 257, 32'(locked), 32'd1);
        chk("wrap.err_count", 257, 32'(err_count), 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
